// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Optional bubble/stall performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf #(
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned           CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              accept;
  logic              release_w;

  // Ready depends only on registered state, so backpressure never forms a combinational path upstream.
  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_d_q;
  assign occ_o       = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign accept    = in_valid_i & in_ready_o;
  assign release_w = main_v_q & out_ready_i & ~stall_i;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d_d = FLUSH_VAL;
      skid_d_d = FLUSH_VAL;
    end else if (skid_v_q && release_w) begin
      main_d_d = skid_d_q;
      skid_v_d = 1'b0;
    end else if (!main_v_q && accept) begin
      main_d_d = in_data_i;
      main_v_d = 1'b1;
    end else if (main_v_q && release_w && accept) begin
      main_d_d = in_data_i;
    end else if (main_v_q && release_w) begin
      main_v_d = 1'b0;
    end else if (main_v_q && accept) begin
      skid_d_d = in_data_i;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= FLUSH_VAL;
      skid_d_q <= FLUSH_VAL;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic             bubble_ev;
  logic             stall_ev;

  assign bubble_ev = out_ready_i & ~stall_i & ~main_v_q & ~flush_i;
  assign stall_ev  = main_v_q & (~out_ready_i | stall_i);

  // Saturating counters; only reset clears them.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bubble_ev && (bubble_cnt_q != {CNT_W{1'b1}})) bubble_cnt_d = bubble_cnt_q + 1'b1;
    if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}}))   stall_cnt_d  = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`else
  assign bubble_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (counter expectations follow PIPE_STAGE_PERF_EN).
module tb_pipe_stage_buf;
  localparam int unsigned     DATA_W = 32;
  localparam int unsigned     CNT_W  = 4;
  localparam logic [31:0]     FV     = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, stall, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  int n_vec = 0;
  int n_bad = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .FLUSH_VAL(FV), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occ_o(occ), .bubble_cnt_o(bubble_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    flush = 0; stall = 0;
    drive(0, 0, 0);
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    do_reset();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_data", out_data, FV);
    check_eq("rst_occ", occ, 0);
    check_eq("rst_bcnt", bubble_cnt, 0);
    check_eq("rst_scnt", stall_cnt, 0);

    // Streaming
    drive(1, 32'h1, 1); step();
    check_eq("str1_data", out_data, 32'h1);
    check_eq("str1_valid", out_valid, 1);
    check_eq("str1_occ", occ, 1);
    drive(1, 32'h2, 1); step();
    check_eq("str2_data", out_data, 32'h2);
    check_eq("str2_ready", in_ready, 1);
    drive(1, 32'h3, 1); step();
    check_eq("str3_data", out_data, 32'h3);
    check_eq("str3_occ", occ, 1);
    drive(0, 0, 1); step();
    check_eq("str_drain_valid", out_valid, 0);
    check_eq("str_drain_hold", out_data, 32'h3);
    check_eq("str_drain_occ", occ, 0);

    // Backpressure
    do_reset();
    drive(1, 32'hA, 0); step();
    check_eq("bp_a_occ", occ, 1);
    check_eq("bp_a_ready", in_ready, 1);
    drive(1, 32'hB, 0); step();
    check_eq("bp_b_occ", occ, 2);
    check_eq("bp_b_ready", in_ready, 0);
    check_eq("bp_b_data", out_data, 32'hA);
    drive(1, 32'hC, 0); step();
    check_eq("bp_c_occ", occ, 2);
    check_eq("bp_c_data", out_data, 32'hA);
    drive(1, 32'hC, 1); step();
    check_eq("bp_rel1_data", out_data, 32'hB);
    check_eq("bp_rel1_ready", in_ready, 1);
    check_eq("bp_rel1_occ", occ, 1);
    drive(1, 32'hC, 1); step();
    check_eq("bp_rel2_data", out_data, 32'hC);
    check_eq("bp_rel2_valid", out_valid, 1);
    drive(0, 0, 1); step();
    check_eq("bp_end_valid", out_valid, 0);
    check_eq("bp_end_occ", occ, 0);

    // Stall
    do_reset();
    drive(1, 32'h55, 0); step();
    drive(0, 0, 1); stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_data", out_data, 32'h55);
      check_eq("stall_valid", out_valid, 1);
    end
`ifdef PIPE_STAGE_PERF_EN
    check_eq("stall_cnt", stall_cnt, 3);
`else
    check_eq("stall_cnt", stall_cnt, 0);
`endif
    stall = 0; step();
    check_eq("stall_end_valid", out_valid, 0);

    // Flush with a concurrent input
    do_reset();
    drive(1, 32'h1, 0); step();
    drive(1, 32'h2, 0); step();
    check_eq("fl_pre_occ", occ, 2);
    flush = 1; drive(1, 32'h77, 0); step();
    flush = 0;
    check_eq("fl_occ", occ, 0);
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_data", out_data, FV);
    check_eq("fl_ready", in_ready, 1);
    drive(0, 0, 1); step();
    check_eq("fl_no77_valid", out_valid, 0);
    check_eq("fl_no77_data", out_data, FV);

    // Asynchronous reset mid-operation
    do_reset();
    drive(1, 32'h4, 0); step();
    drive(1, 32'h5, 0); step();
    check_eq("ar_pre_occ", occ, 2);
    #2 rst_n = 0;
    #1;
    check_eq("ar_valid", out_valid, 0);
    check_eq("ar_ready", in_ready, 1);
    check_eq("ar_data", out_data, FV);
    check_eq("ar_occ", occ, 0);
    check_eq("ar_scnt", stall_cnt, 0);
    drive(0, 0, 0);
    step();
    rst_n = 1;
    drive(1, 32'h9, 1); step();
    check_eq("ar_new_data", out_data, 32'h9);
    check_eq("ar_new_valid", out_valid, 1);

    // Bubble counter saturation
    do_reset();
    drive(0, 0, 1);
    for (int i = 0; i < 20; i++) step();
`ifdef PIPE_STAGE_PERF_EN
    check_eq("bub_sat", bubble_cnt, 4'hF);
`else
    check_eq("bub_sat", bubble_cnt, 0);
`endif
    check_eq("bub_scnt", stall_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
